// File: rtl/skew_sync_ctrl.sv
// Job sequencer for a two-stream skewed synchronizer: probe which stream carries
// more ones, then pass that lane through and skew the other with a saturating pending counter.
module skew_sync_ctrl #(
    parameter int DEPTH = 2,
    parameter int LEN_W = 8,
    parameter int PROBE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       in,
    input  logic             in_valid,
    output logic [1:0]       out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             swap,
    output logic [DEPTH-1:0] resid
);
    localparam int PC_W = $clog2(PROBE + 1);
    localparam logic [DEPTH-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [PC_W-1:0]  probe_cnt;
    logic [PC_W-1:0]  ones0;
    logic [PC_W-1:0]  ones1;
    logic [DEPTH-1:0] pend;

    logic             hi;
    logic             lo;
    logic             lo_o;
    logic [DEPTH-1:0] pend_next;
    logic [PC_W-1:0]  ones0_next;
    logic [PC_W-1:0]  ones1_next;
    logic             last_bit;

    // A lo one with no hi partner is parked in pend and released on a later
    // hi-only cycle, so ones line up and correlation rises.
    always_comb begin
        hi        = swap ? in[0] : in[1];
        lo        = swap ? in[1] : in[0];
        lo_o      = lo;
        pend_next = pend;
        if (lo && !hi) begin
            if (pend != PEND_MAX) begin
                lo_o      = 1'b0;
                pend_next = pend + 1'b1;
            end
        end else if (!lo && hi) begin
            if (pend != '0) begin
                lo_o      = 1'b1;
                pend_next = pend - 1'b1;
            end
        end
    end

    // Output is qualified by out_valid and forced to zero whenever it is low.
    always_comb begin
        out_valid = in_valid & busy;
        out       = 2'b00;
        if (out_valid) begin
            if (state == S_RUN) begin
                out = swap ? {lo_o, hi} : {hi, lo_o};
            end else begin
                out = in;
            end
        end
    end

    always_comb begin
        ones0_next = ones0 + PC_W'(in[0]);
        ones1_next = ones1 + PC_W'(in[1]);
        last_bit   = (remaining == LEN_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            probe_cnt <= '0;
            ones0     <= '0;
            ones1     <= '0;
            pend      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            swap      <= 1'b0;
            resid     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= len;
                        probe_cnt <= '0;
                        ones0     <= '0;
                        ones1     <= '0;
                        pend      <= '0;
                        swap      <= 1'b0;
                        resid     <= '0;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_PROBE;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_PROBE: begin
                    if (in_valid) begin
                        remaining <= remaining - 1'b1;
                        probe_cnt <= probe_cnt + 1'b1;
                        ones0     <= ones0_next;
                        ones1     <= ones1_next;
                        if (probe_cnt == PC_W'(PROBE - 1)) begin
                            swap <= (ones0_next > ones1_next);
                        end
                        if (last_bit) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            resid <= pend;
                        end else if (probe_cnt == PC_W'(PROBE - 1)) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        remaining <= remaining - 1'b1;
                        pend      <= pend_next;
                        if (last_bit) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            resid <= pend_next;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_skew_sync_ctrl.sv
// Directed plus randomized bench for skew_sync_ctrl against a cycle-level behavioural model.
module tb_skew_sync_ctrl;
    localparam int DEPTH = 2;
    localparam int LEN_W = 8;
    localparam int PROBE = 16;
    localparam int PMAX  = (1 << DEPTH) - 1;
    localparam int M_IDLE = 0, M_PROBE = 1, M_RUN = 2, M_DONE = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [1:0]       in;
    logic             in_valid;
    logic [1:0]       out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             swap;
    logic [DEPTH-1:0] resid;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model of the job
    int   m_phase, m_rem, m_pc, m_o0, m_o1, m_p, m_resid;
    logic m_swap;
    int   lo_in_cnt, lo_out_cnt;
    logic ran_run;

    logic [1:0] last_out;
    logic       last_done, last_busy, last_ov;

    skew_sync_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W), .PROBE(PROBE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in(in),
        .in_valid(in_valid), .out(out), .out_valid(out_valid), .busy(busy),
        .done(done), .swap(swap), .resid(resid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_IDLE; m_rem = 0; m_pc = 0; m_o0 = 0; m_o1 = 0;
        m_p = 0; m_resid = 0; m_swap = 1'b0;
        lo_in_cnt = 0; lo_out_cnt = 0; ran_run = 1'b0;
    endtask

    function automatic logic [1:0] model_out(input logic [1:0] d, input logic v);
        logic hi_b, lo_b, lo_res;
        if (!v || !(m_phase == M_PROBE || m_phase == M_RUN)) return 2'b00;
        if (m_phase == M_PROBE) return d;
        hi_b   = m_swap ? d[0] : d[1];
        lo_b   = m_swap ? d[1] : d[0];
        lo_res = lo_b;
        if (lo_b && !hi_b) lo_res = (m_p == PMAX);
        else if (hi_b && !lo_b) lo_res = (m_p > 0);
        return m_swap ? {lo_res, hi_b} : {hi_b, lo_res};
    endfunction

    task automatic model_step(input logic st, input logic [LEN_W-1:0] ln,
                              input logic [1:0] d, input logic v);
        int hi_i, lo_i;
        case (m_phase)
            M_IDLE: if (st) begin
                m_swap = 1'b0; m_resid = 0; m_p = 0; m_o0 = 0; m_o1 = 0; m_pc = 0;
                m_rem = int'(ln);
                lo_in_cnt = 0; lo_out_cnt = 0; ran_run = 1'b0;
                m_phase = (ln == 0) ? M_DONE : M_PROBE;
            end
            M_PROBE: if (v) begin
                m_rem--; m_pc++;
                m_o0 += int'(d[0]); m_o1 += int'(d[1]);
                if (m_pc == PROBE) m_swap = (m_o0 > m_o1);
                if (m_rem == 0) begin
                    m_resid = m_p; m_phase = M_DONE;
                end else if (m_pc == PROBE) begin
                    m_phase = M_RUN; ran_run = 1'b1;
                end
            end
            M_RUN: if (v) begin
                hi_i = int'(m_swap ? d[0] : d[1]);
                lo_i = int'(m_swap ? d[1] : d[0]);
                if (lo_i > hi_i && m_p < PMAX) m_p++;
                else if (hi_i > lo_i && m_p > 0) m_p--;
                m_rem--;
                if (m_rem == 0) begin
                    m_resid = m_p; m_phase = M_DONE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic cycle(input logic st, input logic [LEN_W-1:0] ln,
                         input logic [1:0] d, input logic v);
        logic [1:0] eo;
        logic       busy_exp;
        @(negedge clk);
        start = st; len = ln; in = d; in_valid = v;
        #1;
        busy_exp = (m_phase == M_PROBE || m_phase == M_RUN);
        eo = model_out(d, v);
        check("out", out, eo);
        check("out_valid", out_valid, v && busy_exp);
        check("busy", busy, busy_exp);
        check("done", done, m_phase == M_DONE);
        check("swap", swap, m_swap);
        check("resid", resid, m_resid);
        if (m_phase == M_RUN && v) begin
            lo_in_cnt  += int'(m_swap ? d[1] : d[0]);
            lo_out_cnt += int'(m_swap ? out[1] : out[0]);
        end
        if (m_phase == M_DONE && ran_run) check("conserve", lo_out_cnt + int'(resid), lo_in_cnt);
        last_out = out; last_done = done; last_busy = busy; last_ov = out_valid;
        @(posedge clk);
        model_step(st, ln, d, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in = 2'b00;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_out", out, 2'b00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_swap", swap, 1'b0);
        check("rst_resid", resid, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [1:0]       d;
        logic [LEN_W-1:0] ln;
        int               guard;
        logic [4:0]       sat_exp;

        rst_n = 1'b0; start = 1'b0; len = '0; in = 2'b00; in_valid = 1'b0;
        model_reset();
        do_reset();

        // probe picks in[0]; no lo-only bits ever arise
        cycle(1'b1, 8'd40, 2'b00, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, {(i % 2 == 0), 1'b1}, 1'b1);
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("t1_done_cycle41", last_done, 1'b1);
        check("t1_swap", swap, 1'b1);
        check("t1_resid", resid, 0);
        cycle(1'b0, '0, 2'b00, 1'b0);

        // saturation, release, empty counter
        cycle(1'b1, 8'd30, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 2'b00, 1'b1);
        sat_exp = 5'b11000;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 2'b01, 1'b1);
            check("sat_out0", last_out[0], sat_exp[i]);
        end
        cycle(1'b0, '0, 2'b10, 1'b1);
        check("release_out", last_out, 2'b11);
        cycle(1'b0, '0, 2'b10, 1'b1);
        cycle(1'b0, '0, 2'b10, 1'b1);
        cycle(1'b0, '0, 2'b10, 1'b1);
        check("empty_out", last_out, 2'b10);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 2'b01, 1'b1);
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("sat_done", last_done, 1'b1);
        check("sat_resid", resid, 3);
        check("sat_swap", swap, 1'b0);
        cycle(1'b0, '0, 2'b00, 1'b0);

        // short job never reaches RUN
        cycle(1'b1, 8'd5, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d = rnd2();
            cycle(1'b0, '0, d, 1'b1);
            check("short_pass", last_out, d);
        end
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("short_done", last_done, 1'b1);
        check("short_swap", swap, 1'b0);
        check("short_resid", resid, 0);
        cycle(1'b0, '0, 2'b00, 1'b0);

        // gaps, ignored start while busy and in DONE, zero-length job
        cycle(1'b1, 8'd24, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, rnd2(), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, rnd2(), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(i == 1, 8'd9, 2'b11, 1'b0);
            check("gap_ov", last_ov, 1'b0);
            check("gap_out", last_out, 2'b00);
            check("gap_busy", last_busy, 1'b1);
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, rnd2(), 1'b1);
        cycle(1'b1, 8'd7, 2'b00, 1'b0);
        check("gap_done", last_done, 1'b1);
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("done_start_ignored", last_busy, 1'b0);
        cycle(1'b1, 8'd0, 2'b00, 1'b0);
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("len0_done", last_done, 1'b1);
        cycle(1'b0, '0, 2'b00, 1'b0);
        check("len0_done_single", last_done, 1'b0);

        // reset mid-RUN with two pending ones
        cycle(1'b1, 8'd50, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 2'b00, 1'b1);
        cycle(1'b0, '0, 2'b01, 1'b1);
        cycle(1'b0, '0, 2'b01, 1'b1);
        do_reset();
        cycle(1'b1, 8'd20, 2'b00, 1'b0);
        guard = 0;
        while (m_phase != M_IDLE && guard < 200) begin
            cycle(1'b0, '0, rnd2(), 1'b1);
            guard++;
        end
        check("post_reset_job_end", guard < 200, 1'b1);

        // randomized jobs with gaps and stray start pulses
        for (int j = 0; j < 24; j++) begin
            ln = LEN_W'($urandom_range(1, 60));
            if (ln == LEN_W'(PROBE)) ln = ln + 1'b1;
            cycle(1'b1, ln, rnd2(), 1'($urandom_range(0, 1)));
            guard = 0;
            while (m_phase != M_IDLE && guard < 400) begin
                cycle($urandom_range(0, 9) == 0, LEN_W'($urandom_range(0, 255)),
                      rnd2(), $urandom_range(0, 9) < 8);
                guard++;
            end
            check("rand_job_end", guard < 400, 1'b1);
            if ($urandom_range(0, 1) == 1) cycle(1'b0, '0, rnd2(), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
